race_progress_tracker: RTL and testbench
========================================

// Module: race_progress_tracker
// PURPOSE
//  Parametrised checkpoint/lap tracker for one kart, fed by the physics engine's front-box centre.
//  Enforces an ordered set of NUM_CP rectangular checkpoints, counts laps to NUM_LAPS, and runs tick-based timers.
//  Timers are current lap, last lap, best lap and total race time. It also flags out-of-order entries (wrong way).
//  One instance per player, between the physics engine and the HUD/result logic.
// PARAMETERS
//  CLK_FREQ    100_000_000  system clock Hz
//  TICK_HZ     120          timer tick rate; TICK_LIMIT = CLK_FREQ/TICK_HZ clocks per tick
//  NUM_CP      4            checkpoints, 2..8; CP0 is the start/finish line
//  NUM_LAPS    3            laps to finish, 1..15
//  RACE_STATE  3'd4         value of state[] meaning "race running"
//  CP_X_MIN    {NUM_CP{10'd0}}  packed 10b per CP, CP i at [10*i+:10]; same packing for the next three
//  CP_X_MAX    {NUM_CP{10'd0}}  region upper x bound (exclusive)
//  CP_Y_MIN    {NUM_CP{10'd0}}  region lower y bound (exclusive)
//  CP_Y_MAX    {NUM_CP{10'd0}}  region upper y bound (exclusive)
//  TIME_W      16           timer width in ticks
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous reset, active-high
//  state      in   3          global game state
//  pos_x      in   10         kart front-box x
//  pos_y      in   10         kart front-box y
//  next_cp    out  3          index of checkpoint expected next
//  lap        out  4          completed laps, 0..NUM_LAPS
//  lap_time   out  TIME_W     ticks in current lap
//  last_lap   out  TIME_W     duration of most recent completed lap
//  best_lap   out  TIME_W     minimum completed lap duration
//  total_time out  TIME_W     ticks since race start
//  lap_done   out  1          1-clk pulse on lap completion
//  wrong_way  out  1          sticky out-of-order flag
//  finish     out  1          high once lap==NUM_LAPS; held until rst
// BEHAVIOUR
//  Reset values:
//  - next_cp=1, lap=0, all timers 0, best_lap=all-ones, lap_done=0, wrong_way=0, finish=0.
//  - FSM=IDLE, tick counter=0, region registers=0.
//  Tick counter: free-runs from reset; tick is a 1-clk strobe when count==TICK_LIMIT-1, then it wraps to 0.
//  Region test, per CP:
//  - in_i = XMIN<x<XMAX && YMIN<y<YMAX (strict compares), registered every clk.
//  - enter_i = in_i & ~in_i_d (rising edge); one extra register stage, so 2 clk from position to event.
//  - Holding inside a region never re-triggers.
//  FSM:
//  - IDLE -> RACING when state==RACE_STATE.
//  - RACING -> FINISHED on the lap completion that makes lap==NUM_LAPS.
//  - FINISHED -> IDLE only by rst.
//  - While RACING and state!=RACE_STATE (pause): timers and checkpoint logic are frozen; region registers keep sampling.
//  Timers:
//  - In RACING with state==RACE_STATE, each tick increments lap_time and total_time.
//  - Both saturate at all-ones.
//  - In IDLE and FINISHED all timers hold.
//  Checkpoint advance:
//  - enter of CP next_cp, with next_cp!=0 -> next_cp = (next_cp+1) mod NUM_CP.
//  - enter of CP0 with next_cp==0 is lap completion:
//    - lap+1; last_lap=lap_time; best_lap=min(best_lap,lap_time); lap_time=0; next_cp=1; lap_done=1 for 1 clk.
//    - The captured value is the pre-increment lap_time even if a tick coincides; lap_time becomes 0, not 1.
//  Wrong way:
//  - Entering a CP that is neither next_cp nor the last cleared CP ((next_cp-1) mod NUM_CP) sets wrong_way.
//  - The next valid advance clears it.
//  Simultaneous events:
//  - Overlapping regions entered in the same clk: only the expected CP advances; wrong_way is not set that clk.
//  - At most one advance per clk.
//  Finish: finish=1 in the same clk as the final lap_done; afterwards enters are ignored and outputs hold.
//  rst mid-race restores all reset values next clk, regardless of state or FSM.
// TESTING  (CLK_FREQ=1200, TICK_HZ=120 -> 10 clk/tick; NUM_CP=4, NUM_LAPS=2)
//  1. Reset, state=4, park in CP0 for 100 clk -> next_cp=1, lap=0, lap_time=10, total_time=10, no lap_done.
//  2. Visit CP1,2,3,0 in order, reaching CP0 at tick 37 -> lap=1, last_lap=37, best_lap=37, lap_time=0, one lap_done pulse.
//  3. Following lap 1, go from CP1 to CP3 skipping CP2 -> wrong_way=1, next_cp=2.
//     Then CP2 -> wrong_way=0, next_cp=3.
//  4. Second lap in 25 ticks -> lap=2, best_lap=25, last_lap=25, finish=1.
//     Hold 50 clk and re-enter CP1 -> total_time and next_cp unchanged.
//  5. Mid-lap, set state=3 for 200 clk -> lap_time/total_time frozen; state=4 resumes counting from the frozen values.
//  6. Lap completion aligned with tick strobe -> last_lap equals pre-tick value, lap_time=0.
//     rst asserted mid-lap -> all outputs at reset values next clk.

Source files
------------

// File: rtl/race_progress_tracker_if.sv
// Purpose: bundles the kart position/game-state inputs and the lap/timer results of one race tracker.
// Latency: none (wiring only).
// Backpressure: none; the tracker samples every clock and results are level outputs.
//
// Ports (master = physics/HUD side, slave = tracker):
//   state, pos_x, pos_y                       master -> slave
//   next_cp, lap, lap_time, last_lap,
//   best_lap, total_time, lap_done,
//   wrong_way, finish                         slave  -> master
interface race_progress_tracker_if #(
    parameter int TIME_W = 16
) ();
    logic [2:0]        state;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic [2:0]        next_cp;
    logic [3:0]        lap;
    logic [TIME_W-1:0] lap_time;
    logic [TIME_W-1:0] last_lap;
    logic [TIME_W-1:0] best_lap;
    logic [TIME_W-1:0] total_time;
    logic              lap_done;
    logic              wrong_way;
    logic              finish;

    modport master (
        output state, pos_x, pos_y,
        input  next_cp, lap, lap_time, last_lap, best_lap, total_time,
               lap_done, wrong_way, finish
    );

    modport slave (
        input  state, pos_x, pos_y,
        output next_cp, lap, lap_time, last_lap, best_lap, total_time,
               lap_done, wrong_way, finish
    );
endinterface

// File: rtl/race_progress_tracker.sv
// Purpose: per-kart checkpoint/lap tracker with tick-based lap, best-lap and race timers.
// Latency: position -> checkpoint event 2 clk; outputs update on the following clk.
// Backpressure: none; inputs are sampled every clock, outputs are registered levels/pulses.
//
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries
//   state/pos_x/pos_y in and next_cp/lap/timers/lap_done/wrong_way/finish out.
module race_progress_tracker #(
    parameter int                     CLK_FREQ   = 100_000_000,
    parameter int                     TICK_HZ    = 120,
    parameter int                     NUM_CP     = 4,
    parameter int                     NUM_LAPS   = 3,
    parameter logic [2:0]             RACE_STATE = 3'd4,
    parameter logic [10*NUM_CP-1:0]   CP_X_MIN   = {NUM_CP{10'd0}},
    parameter logic [10*NUM_CP-1:0]   CP_X_MAX   = {NUM_CP{10'd0}},
    parameter logic [10*NUM_CP-1:0]   CP_Y_MIN   = {NUM_CP{10'd0}},
    parameter logic [10*NUM_CP-1:0]   CP_Y_MAX   = {NUM_CP{10'd0}},
    parameter int                     TIME_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    race_progress_tracker_if.slave    bus
);

    localparam int TICK_LIMIT = CLK_FREQ / TICK_HZ;
    localparam int CNT_W      = (TICK_LIMIT > 1) ? $clog2(TICK_LIMIT) : 1;

    typedef enum logic [1:0] {IDLE, RACING, FINISHED} fsm_t;

    fsm_t              fsm;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;

    logic [NUM_CP-1:0] in_now;
    logic [NUM_CP-1:0] in_r;
    logic [NUM_CP-1:0] in_d;
    logic [NUM_CP-1:0] enter_r;
    logic [NUM_CP-1:0] exp_oh;
    logic [NUM_CP-1:0] prev_oh;
    logic              hit_next;
    logic              hit_wrong;
    logic              running;

    logic [2:0]        next_cp;
    logic [2:0]        prev_cp;
    logic [2:0]        cp_after;
    logic [3:0]        lap;
    logic [TIME_W-1:0] lap_time;
    logic [TIME_W-1:0] last_lap;
    logic [TIME_W-1:0] best_lap;
    logic [TIME_W-1:0] total_time;
    logic              lap_done;
    logic              wrong_way;
    logic              finish;

    assign tick    = (tick_cnt == CNT_W'(TICK_LIMIT - 1));
    assign running = (bus.state == RACE_STATE);

    // Checkpoint order wraps: the one cleared before CP0 is NUM_CP-1.
    assign prev_cp  = (next_cp == 3'd0) ? 3'(NUM_CP - 1) : next_cp - 3'd1;
    assign cp_after = (next_cp == 3'(NUM_CP - 1)) ? 3'd0 : next_cp + 3'd1;

    always_comb begin
        in_now  = '0;
        exp_oh  = '0;
        prev_oh = '0;
        for (int i = 0; i < NUM_CP; i++) begin
            in_now[i]  = (bus.pos_x > CP_X_MIN[10*i +: 10]) && (bus.pos_x < CP_X_MAX[10*i +: 10]) &&
                         (bus.pos_y > CP_Y_MIN[10*i +: 10]) && (bus.pos_y < CP_Y_MAX[10*i +: 10]);
            exp_oh[i]  = (next_cp == 3'(i));
            prev_oh[i] = (prev_cp == 3'(i));
        end
    end

    // The expected checkpoint wins over any overlapping region entered in the same clk,
    // and re-entering the checkpoint just cleared is tolerated (kart wobbling on a line).
    assign hit_next  = |(enter_r & exp_oh);
    assign hit_wrong = |(enter_r & ~exp_oh & ~prev_oh);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= IDLE;
            tick_cnt   <= '0;
            in_r       <= '0;
            in_d       <= '0;
            enter_r    <= '0;
            next_cp    <= 3'd1;
            lap        <= 4'd0;
            lap_time   <= '0;
            last_lap   <= '0;
            best_lap   <= '1;
            total_time <= '0;
            lap_done   <= 1'b0;
            wrong_way  <= 1'b0;
            finish     <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);

            // Region sampling never pauses so a kart already inside a region on
            // resume does not generate a spurious entry.
            in_r     <= in_now;
            in_d     <= in_r;
            enter_r  <= in_r & ~in_d;
            lap_done <= 1'b0;

            case (fsm)
                IDLE: begin
                    if (running) begin
                        fsm <= RACING;
                    end
                end

                RACING: begin
                    if (running) begin
                        if (tick && (total_time != '1)) begin
                            total_time <= total_time + TIME_W'(1);
                        end

                        if (hit_next && (next_cp == 3'd0)) begin
                            // Lap completion captures the pre-tick value and restarts at 0
                            // even when a tick strobe lands on the same clk.
                            lap      <= lap + 4'd1;
                            last_lap <= lap_time;
                            if (lap_time < best_lap) begin
                                best_lap <= lap_time;
                            end
                            lap_time  <= '0;
                            next_cp   <= 3'd1;
                            lap_done  <= 1'b1;
                            wrong_way <= 1'b0;
                            if (lap == 4'(NUM_LAPS - 1)) begin
                                fsm    <= FINISHED;
                                finish <= 1'b1;
                            end
                        end else begin
                            if (tick && (lap_time != '1)) begin
                                lap_time <= lap_time + TIME_W'(1);
                            end
                            if (hit_next) begin
                                next_cp   <= cp_after;
                                wrong_way <= 1'b0;
                            end else if (hit_wrong) begin
                                wrong_way <= 1'b1;
                            end
                        end
                    end
                end

                FINISHED: begin
                    // Results are frozen until reset.
                end

                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.next_cp    = next_cp;
    assign bus.lap        = lap;
    assign bus.lap_time   = lap_time;
    assign bus.last_lap   = last_lap;
    assign bus.best_lap   = best_lap;
    assign bus.total_time = total_time;
    assign bus.lap_done   = lap_done;
    assign bus.wrong_way  = wrong_way;
    assign bus.finish     = finish;

endmodule

// File: tb/tb_race_progress_tracker.sv
// Purpose: directed bench for race_progress_tracker with a queue-based scoreboard.
// Latency: checks outputs on the falling edge after each stimulus point.
// Backpressure: none; the monitor pops one expectation per lap_done pulse or snapshot request.
module tb_race_progress_tracker;

    localparam int TIME_W = 16;

    typedef struct {
        int          tag;
        logic [2:0]  next_cp;
        logic [3:0]  lap;
        logic [15:0] lap_time;
        logic [15:0] last_lap;
        logic [15:0] best_lap;
        logic [15:0] total_time;
        logic        lap_done;
        logic        wrong_way;
        logic        finish;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    exp_t snap_q[$];
    exp_t lap_q[$];

    race_progress_tracker_if #(.TIME_W(TIME_W)) bus ();

    race_progress_tracker #(
        .CLK_FREQ   (1200),
        .TICK_HZ    (120),
        .NUM_CP     (4),
        .NUM_LAPS   (2),
        .RACE_STATE (3'd4),
        .CP_X_MIN   ({10'd310, 10'd210, 10'd110, 10'd10}),
        .CP_X_MAX   ({10'd360, 10'd260, 10'd160, 10'd60}),
        .CP_Y_MIN   ({4{10'd10}}),
        .CP_Y_MAX   ({4{10'd60}}),
        .TIME_W     (TIME_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clocks since the last reset edge; edge N is the N-th rising edge with rst low.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string what, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", what, tag, act, exp, $time);
        end
    endtask

    task automatic compare_rec(input exp_t e);
        chk("next_cp",    e.tag, 32'(bus.next_cp),    32'(e.next_cp));
        chk("lap",        e.tag, 32'(bus.lap),        32'(e.lap));
        chk("lap_time",   e.tag, 32'(bus.lap_time),   32'(e.lap_time));
        chk("last_lap",   e.tag, 32'(bus.last_lap),   32'(e.last_lap));
        chk("best_lap",   e.tag, 32'(bus.best_lap),   32'(e.best_lap));
        chk("total_time", e.tag, 32'(bus.total_time), 32'(e.total_time));
        chk("lap_done",   e.tag, 32'(bus.lap_done),   32'(e.lap_done));
        chk("wrong_way",  e.tag, 32'(bus.wrong_way),  32'(e.wrong_way));
        chk("finish",     e.tag, 32'(bus.finish),     32'(e.finish));
    endtask

    // Monitor: lap_done acts as the output valid for lap records; snapshot
    // requests are compared on the falling edge after they are issued.
    always @(negedge clk) begin
        if (bus.lap_done === 1'b1) begin
            if (lap_q.size() == 0) begin
                chk("unexpected_lap_done", cyc, 32'd1, 32'd0);
            end else begin
                compare_rec(lap_q.pop_front());
            end
        end
        if (snap_q.size() > 0) begin
            compare_rec(snap_q.pop_front());
        end
    end

    function automatic exp_t mk(input int tag, input int ncp, input int lp, input int lt, input int last,
                                input int best, input int tot, input int done, input int ww, input int fin);
        exp_t e;
        e.tag        = tag;
        e.next_cp    = 3'(ncp);
        e.lap        = 4'(lp);
        e.lap_time   = 16'(lt);
        e.last_lap   = 16'(last);
        e.best_lap   = 16'(best);
        e.total_time = 16'(tot);
        e.lap_done   = 1'(done);
        e.wrong_way  = 1'(ww);
        e.finish     = 1'(fin);
        return e;
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // cp < 0 parks the kart away from every checkpoint.
    task automatic set_pos(input int cp);
        if (cp < 0) begin
            bus.pos_x = 10'd500;
            bus.pos_y = 10'd500;
        end else begin
            bus.pos_x = 10'(100 * cp + 35);
            bus.pos_y = 10'd35;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected end before t=200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.state = 3'd4;
        set_pos(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Both laps produce exactly one lap_done each.
        lap_q.push_back(mk(100, 1, 1, 0, 37, 37, 37, 1, 0, 0));
        // Second lap ends on a tick edge: 25 captured, lap_time 0, total still ticks to 63.
        lap_q.push_back(mk(101, 1, 2, 0, 25, 25, 63, 1, 0, 1));

        snap_q.push_back(mk(0, 1, 0, 0, 0, 16'hffff, 0, 0, 0, 0));

        // Parked in CP0 since reset: CP0 is the last-cleared CP, so no wrong_way.
        wait_cyc(100);
        snap_q.push_back(mk(1, 1, 0, 10, 0, 16'hffff, 10, 0, 0, 0));
        set_pos(1);
        wait_cyc(150); set_pos(2);
        wait_cyc(200); set_pos(3);
        // Enter at 372 -> lap completion on edge 375 with lap_time 37.
        wait_cyc(372); set_pos(0);
        wait_cyc(400); set_pos(-1);

        // Skip CP2: CP1 then CP3.
        wait_cyc(410); set_pos(1);
        wait_cyc(430); set_pos(3);
        wait_cyc(433);
        snap_q.push_back(mk(2, 2, 1, 6, 37, 37, 43, 0, 1, 0));
        wait_cyc(450); set_pos(2);
        wait_cyc(453);
        snap_q.push_back(mk(3, 3, 1, 8, 37, 37, 45, 0, 0, 0));

        // Pause for 200 clk; entering CP3 meanwhile must not advance.
        wait_cyc(460); bus.state = 3'd3;
        wait_cyc(480); set_pos(-1);
        wait_cyc(500); set_pos(3);
        wait_cyc(540); set_pos(-1);
        wait_cyc(560);
        snap_q.push_back(mk(4, 3, 1, 9, 37, 37, 46, 0, 0, 0));
        wait_cyc(660);
        snap_q.push_back(mk(5, 3, 1, 9, 37, 37, 46, 0, 0, 0));
        bus.state = 3'd4;
        wait_cyc(700);
        snap_q.push_back(mk(6, 3, 1, 13, 37, 37, 50, 0, 0, 0));

        wait_cyc(710); set_pos(3);
        // Completion lands on edge 830, a tick edge.
        wait_cyc(827); set_pos(0);
        wait_cyc(840); set_pos(-1);
        wait_cyc(880); set_pos(1);
        wait_cyc(900);
        snap_q.push_back(mk(7, 1, 2, 0, 25, 25, 63, 0, 0, 1));

        // New race after reset, then reset in the middle of a lap.
        wait_cyc(905);
        set_pos(-1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        snap_q.push_back(mk(8, 1, 0, 0, 0, 16'hffff, 0, 0, 0, 0));
        wait_cyc(20); set_pos(1);
        wait_cyc(50);
        snap_q.push_back(mk(9, 2, 0, 5, 0, 16'hffff, 5, 0, 0, 0));
        wait_cyc(55);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        snap_q.push_back(mk(10, 1, 0, 0, 0, 16'hffff, 0, 0, 0, 0));

        repeat (5) @(posedge clk);
        #1;
        chk("lap_q_left",  0, 32'(lap_q.size()),  32'd0);
        chk("snap_q_left", 0, 32'(snap_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
